enemy_fire_scheduler: RTL and testbench
=======================================

Name: enemy_fire_scheduler

Overview:
Sequences the enemy (pig) shooters by deciding which enemy projectile mover may launch next and when. It enforces a frame-based cooldown with random jitter, limits the number of projectiles in flight, and picks shooters round-robin. It sits between the game-control logic (preGame, pig alive flags, random generator) and the per-pig enemy projectile movers, driving their fire approval inputs.

Parameters:
NUM_SHOOTERS, 4, number of enemy projectile movers served
COOLDOWN_FRAMES, 30, base frames between two successive grants
JITTER_MASK, 4'hF, mask applied to randomValue[3:0] to form the extra cooldown frames
MAX_ACTIVE, 2, maximum projectiles simultaneously in flight
ACK_TIMEOUT_FRAMES, 4, frames to wait for the granted shooter to start shooting

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
startOfFrame  input  1  one-clk pulse at each frame start (30 Hz)
preGame  input  1  high while the game is not running; suppresses all firing
pig_alive  input  NUM_SHOOTERS  per-shooter enable; bit i high means pig i may fire
shooting  input  NUM_SHOOTERS  per-shooter in-flight flag from the movers
randomValue  input  5  random value; only bits [3:0] are used
fire  output  NUM_SHOOTERS  one-hot fire approval; at most one bit high
timer  output  1  fire-window strobe, high exactly when any fire bit is high
active_count  output  3  popcount of shooting, registered
grant_idx  output  2  index of the last granted shooter

Behaviour:
- Reset (async, active-high): state=IDLE_ST, fire=0, timer=0, active_count=0, grant_idx=0, rr_ptr=0, cooldown counter=0, timeout counter=0.
- active_count: registered popcount(shooting), updated every clk, one-cycle latency.
- States: IDLE_ST, COOLDOWN_ST, SELECT_ST, GRANT_ST.
- IDLE_ST: fire=0. If preGame=0, load cooldown = COOLDOWN_FRAMES + (randomValue[3:0] & JITTER_MASK) and go to COOLDOWN_ST.
- COOLDOWN_ST: decrement the counter on each startOfFrame. When the counter is 0, go to SELECT_ST.
- SELECT_ST: a candidate is any i with pig_alive[i]=1 and shooting[i]=0. If active_count < MAX_ACTIVE and at least one candidate exists:
  - choose the first candidate scanning from rr_ptr upward, wrapping modulo NUM_SHOOTERS;
  - latch grant_idx, rr_ptr <= (grant_idx+1) mod NUM_SHOOTERS;
  - timeout counter = ACK_TIMEOUT_FRAMES;
  - go to GRANT_ST.
  Otherwise stay in SELECT_ST. Grant is registered: fire is asserted the clk after the decision.
- GRANT_ST: fire[grant_idx]=1 and timer=1. Exit to IDLE_ST, with fire=0 on the next clk, on any of:
  - shooting[grant_idx]=1 (ack);
  - pig_alive[grant_idx]=0 (pig killed, grant withdrawn);
  - the timeout counter reaches 0. The counter decrements on startOfFrame.
  Ack takes priority when it coincides with the timeout frame. Every exit reloads cooldown via IDLE_ST.
- preGame=1 in any state: next clk, state=IDLE_ST, fire=0, timer=0, counters cleared. rr_ptr is kept.
- A startOfFrame in the same clk as the state entry counts for the new state only from the next pulse.
- Cooldown width: 8 bits. COOLDOWN_FRAMES+15 must be ≤255; this is checked by an elaboration assertion.
- Only one grant is outstanding at any time. Movers already in flight are never affected.

Decomposition:
- Package enemy_sched_pkg:
  - state enum sched_state_t (4-bit logic);
  - constants SHOOTER_IDX_W=2, CNT_W=8.
- One sub-module is natural: rr_picker, a combinational round-robin first-set finder. Inputs: request vector and rr_ptr. Outputs: valid and index. It is reused later for a bird-launch arbiter.
- Popcount stays inline.

Test Plan:
1. Reset then preGame=0, randomValue=5, pig_alive=4'b1111, shooting=0 → fire=4'b0001 exactly 35 startOfFrame pulses after leaving IDLE_ST; grant_idx=0.
2. After case 1, raise shooting[0] one clk after fire → fire drops next clk; next grant after 30+jitter frames is fire=4'b0010 (round-robin).
3. shooting=4'b0011, MAX_ACTIVE=2, cooldown expires → stays in SELECT_ST with fire=0; drop shooting[1] → fire=4'b0100 within 2 clk.
4. Grant to pig 2, never ack → fire[2] held for exactly 4 startOfFrame pulses, then 0; the next grant goes to pig 3.
5. pig_alive=4'b1010, rr_ptr=0 → grant goes to index 1, then 3, then 1; bits 0 and 2 are never set.
6. preGame pulsed high during GRANT_ST → fire=0 next clk, state=IDLE_ST; async reset asserted mid-COOLDOWN_ST → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared types and widths for the enemy fire scheduler and its helpers.
package enemy_sched_pkg;

  localparam int SHOOTER_IDX_W = 2;
  localparam int CNT_W         = 8;

  typedef enum logic [3:0] {
    IDLE_ST     = 4'd0,
    COOLDOWN_ST = 4'd1,
    SELECT_ST   = 4'd2,
    GRANT_ST    = 4'd3
  } sched_state_t;

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Bundle between game control / projectile movers and the fire scheduler.
// master = game side driving frame, alive and in-flight flags;
// slave  = scheduler returning fire approvals and status.
interface enemy_fire_scheduler_if
  import enemy_sched_pkg::*;
#(
  parameter int NUM_SHOOTERS = 4
) ();

  logic                      startOfFrame;
  logic                      preGame;
  logic [NUM_SHOOTERS-1:0]   pig_alive;
  logic [NUM_SHOOTERS-1:0]   shooting;
  logic [4:0]                randomValue;
  logic [NUM_SHOOTERS-1:0]   fire;
  logic                      timer;
  logic [2:0]                active_count;
  logic [SHOOTER_IDX_W-1:0]  grant_idx;

  modport master (
    output startOfFrame, preGame, pig_alive, shooting, randomValue,
    input  fire, timer, active_count, grant_idx
  );

  modport slave (
    input  startOfFrame, preGame, pig_alive, shooting, randomValue,
    output fire, timer, active_count, grant_idx
  );

endinterface

// File: rtl/enemy_fire_scheduler_rr_picker.sv
// Combinational round-robin first-set finder: returns the first set request
// at or after ptr, wrapping modulo N. Kept generic for reuse by other arbiters.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan farthest-first so the closest set bit to ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr) + k) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: frame-based cooldown with jitter, in-flight limit,
// round-robin shooter choice, one registered fire grant outstanding at a time.
module enemy_fire_scheduler
  import enemy_sched_pkg::*;
#(
  parameter int         NUM_SHOOTERS       = 4,
  parameter int         COOLDOWN_FRAMES    = 30,
  parameter logic [3:0] JITTER_MASK        = 4'hF,
  parameter int         MAX_ACTIVE         = 2,
  parameter int         ACK_TIMEOUT_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  enemy_fire_scheduler_if.slave bus
);

  if (COOLDOWN_FRAMES + 15 > 255) begin : g_cd_range_chk
    $error("COOLDOWN_FRAMES + 15 does not fit the 8-bit cooldown counter");
  end
  if (NUM_SHOOTERS > (1 << SHOOTER_IDX_W)) begin : g_idx_range_chk
    $error("NUM_SHOOTERS exceeds the grant index width");
  end

  sched_state_t             state;
  logic [CNT_W-1:0]         cd_cnt;
  logic [CNT_W-1:0]         to_cnt;
  logic [SHOOTER_IDX_W-1:0] rr_ptr;
  logic [SHOOTER_IDX_W-1:0] grant_q;
  logic [NUM_SHOOTERS-1:0]  fire_q;
  logic                     timer_q;
  logic [2:0]               active_q;

  logic [NUM_SHOOTERS-1:0]  cand;
  logic                     pick_vld;
  logic [SHOOTER_IDX_W-1:0] pick_idx;
  logic [SHOOTER_IDX_W-1:0] pick_next;
  logic [CNT_W-1:0]         cd_load;
  logic                     grant_exit;
  logic                     unused_rand_msb;

  assign unused_rand_msb = bus.randomValue[4];

  // A pig may be picked only if alive and not already in flight.
  assign cand = bus.pig_alive & ~bus.shooting;

  rr_picker #(
    .N     (NUM_SHOOTERS),
    .IDX_W (SHOOTER_IDX_W)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_next = (pick_idx == SHOOTER_IDX_W'(NUM_SHOOTERS - 1)) ? '0 : pick_idx + 1'b1;
  assign cd_load   = CNT_W'(COOLDOWN_FRAMES) + CNT_W'(bus.randomValue[3:0] & JITTER_MASK);

  // Ack, kill and timeout all end the grant the same way, so no ordering is needed.
  assign grant_exit = bus.shooting[grant_q] | ~bus.pig_alive[grant_q] | (to_cnt == '0);

  // Registered in-flight count, one cycle behind shooting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) active_q <= '0;
    else       active_q <= 3'($countones(bus.shooting));
  end

  // Scheduler FSM with registered fire/timer; preGame forces idle but keeps rr_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE_ST;
      cd_cnt  <= '0;
      to_cnt  <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
      fire_q  <= '0;
      timer_q <= 1'b0;
    end else if (bus.preGame) begin
      state   <= IDLE_ST;
      cd_cnt  <= '0;
      to_cnt  <= '0;
      fire_q  <= '0;
      timer_q <= 1'b0;
    end else begin
      case (state)
        IDLE_ST: begin
          fire_q  <= '0;
          timer_q <= 1'b0;
          cd_cnt  <= cd_load;
          state   <= COOLDOWN_ST;
        end
        COOLDOWN_ST: begin
          if (cd_cnt == '0)           state  <= SELECT_ST;
          else if (bus.startOfFrame) cd_cnt <= cd_cnt - CNT_W'(1);
        end
        SELECT_ST: begin
          if (pick_vld && (active_q < 3'(MAX_ACTIVE))) begin
            grant_q <= pick_idx;
            rr_ptr  <= pick_next;
            to_cnt  <= CNT_W'(ACK_TIMEOUT_FRAMES);
            fire_q  <= NUM_SHOOTERS'(1) << pick_idx;
            timer_q <= 1'b1;
            state   <= GRANT_ST;
          end
        end
        GRANT_ST: begin
          if (grant_exit) begin
            fire_q  <= '0;
            timer_q <= 1'b0;
            to_cnt  <= '0;
            state   <= IDLE_ST;
          end else if (bus.startOfFrame) begin
            to_cnt <= to_cnt - CNT_W'(1);
          end
        end
        default: begin
          fire_q  <= '0;
          timer_q <= 1'b0;
          state   <= IDLE_ST;
        end
      endcase
    end
  end

  assign bus.fire         = fire_q;
  assign bus.timer        = timer_q;
  assign bus.active_count = active_q;
  assign bus.grant_idx    = grant_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler: cooldown length, round-robin,
// in-flight limit, ack timeout, dead-pig skipping, preGame and async reset.
module tb_enemy_fire_scheduler;
  import enemy_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enemy_fire_scheduler_if #(.NUM_SHOOTERS(4)) bus ();

  enemy_fire_scheduler #(
    .NUM_SHOOTERS       (4),
    .COOLDOWN_FRAMES    (30),
    .JITTER_MASK        (4'hF),
    .MAX_ACTIVE         (2),
    .ACK_TIMEOUT_FRAMES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic mon_en   = 1'b0;
  logic seen_bad = 1'b0;

  // Watch for fire on dead pigs 0/2 while they are dead.
  always @(negedge clk)
    if (mon_en && (bus.fire[0] || bus.fire[2])) seen_bad <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One startOfFrame pulse followed by three quiet clocks.
  task automatic frames(input int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick(3);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.preGame      = 1'b1;
    bus.pig_alive    = 4'b1111;
    bus.shooting     = 4'b0000;
    bus.randomValue  = 5'd5;
    #12;
    chk("rst_fire",  32'(bus.fire), 32'h0);
    chk("rst_timer", 32'(bus.timer), 32'h0);
    chk("rst_act",   32'(bus.active_count), 32'h0);
    chk("rst_gidx",  32'(bus.grant_idx), 32'h0);
    reset = 1'b0;
    tick(2);
    chk("pregame_quiet", 32'(bus.fire), 32'h0);

    // 1: cooldown 30+5 frames, first grant to pig 0
    bus.preGame = 1'b0;
    tick();
    frames(34);
    chk("t1_before35", 32'(bus.fire), 32'h0);
    frames(1);
    chk("t1_fire",  32'(bus.fire), 32'b0001);
    chk("t1_timer", 32'(bus.timer), 32'h1);
    chk("t1_gidx",  32'(bus.grant_idx), 32'h0);

    // 2: ack from pig 0, next grant round-robins to pig 1
    bus.shooting    = 4'b0001;
    bus.randomValue = 5'd0;
    tick();
    chk("t2_drop",  32'(bus.fire), 32'h0);
    chk("t2_timer", 32'(bus.timer), 32'h0);
    chk("t2_act",   32'(bus.active_count), 32'h1);
    tick();
    frames(29);
    chk("t2_before30", 32'(bus.fire), 32'h0);
    frames(1);
    chk("t2_fire", 32'(bus.fire), 32'b0010);
    chk("t2_gidx", 32'(bus.grant_idx), 32'h1);

    // 3: two in flight blocks selection until one lands
    bus.shooting = 4'b0011;
    tick();
    chk("t3_ackdrop", 32'(bus.fire), 32'h0);
    tick();
    frames(30);
    tick(3);
    chk("t3_blocked", 32'(bus.fire), 32'h0);
    chk("t3_act2",    32'(bus.active_count), 32'h2);
    bus.shooting = 4'b0001;
    tick(2);
    chk("t3_fire", 32'(bus.fire), 32'b0100);
    chk("t3_gidx", 32'(bus.grant_idx), 32'h2);

    // 4: no ack, grant withdrawn after 4 frames; next grant to pig 3
    frames(3);
    chk("t4_hold3", 32'(bus.fire), 32'b0100);
    frames(1);
    chk("t4_timeout", 32'(bus.fire), 32'h0);
    tick();
    frames(29);
    chk("t4_before30", 32'(bus.fire), 32'h0);
    frames(1);
    chk("t4_fire", 32'(bus.fire), 32'b1000);
    chk("t4_gidx", 32'(bus.grant_idx), 32'h3);

    // 5: only pigs 1 and 3 alive, rr_ptr back at 0
    bus.shooting = 4'b1001;
    tick();
    chk("t5_ack3", 32'(bus.fire), 32'h0);
    bus.shooting  = 4'b0000;
    bus.pig_alive = 4'b1010;
    mon_en        = 1'b1;
    tick();
    frames(30);
    chk("t5_g1", 32'(bus.fire), 32'b0010);
    bus.pig_alive = 4'b1000;
    tick();
    chk("t5_kill", 32'(bus.fire), 32'h0);
    bus.pig_alive = 4'b1010;
    tick();
    frames(30);
    chk("t5_g3", 32'(bus.fire), 32'b1000);
    bus.shooting = 4'b1000;
    tick();
    bus.shooting = 4'b0000;
    tick();
    frames(30);
    chk("t5_g1b",  32'(bus.fire), 32'b0010);
    chk("t5_gidx", 32'(bus.grant_idx), 32'h1);
    mon_en = 1'b0;
    tick();
    chk("t5_dead_never", 32'(seen_bad), 32'h0);

    // 6: preGame aborts the grant and keeps rr_ptr; async reset mid-cooldown
    bus.preGame = 1'b1;
    tick();
    chk("t6_pg_fire",  32'(bus.fire), 32'h0);
    chk("t6_pg_timer", 32'(bus.timer), 32'h0);
    tick(3);
    chk("t6_pg_hold", 32'(bus.fire), 32'h0);
    bus.preGame = 1'b0;
    tick();
    frames(30);
    chk("t6_rr_kept", 32'(bus.fire), 32'b1000);
    bus.shooting = 4'b1011;
    tick();
    chk("t6_ack", 32'(bus.fire), 32'h0);
    tick();
    frames(5);
    chk("t6_act3",  32'(bus.active_count), 32'h3);
    chk("t6_gidx3", 32'(bus.grant_idx), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_arst_fire",  32'(bus.fire), 32'h0);
    chk("t6_arst_timer", 32'(bus.timer), 32'h0);
    chk("t6_arst_act",   32'(bus.active_count), 32'h0);
    chk("t6_arst_gidx",  32'(bus.grant_idx), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
